fetch: RTL and testbench

CHIP-8 instruction fetch unit; it produces the 16-bit instruction word that decode consumes.
- Holds the program counter and reads two consecutive bytes from byte-wide program memory through a req/ack handshake.
- Assembles the bytes big-endian (first byte = instruction[15:8]) and presents the word to decode through a valid/ready handshake.
- Execute redirects the PC for JMP, CALL, RET, skips and JMP V0.

---
 rtl/chip8_pkg.sv | 39 +++
 rtl/fetch.sv | 108 ++++++++++
 tb/tb_fetch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// Constants and types shared by the CHIP-8 fetch, decode and execute units.
package chip8_pkg;

  localparam int               ADDR_W   = 12;
  localparam logic [ADDR_W-1:0] RESET_PC = 12'h200;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_REQ_HI = 2'd1,
    FS_REQ_LO = 2'd2,
    FS_HOLD   = 2'd3
  } fetch_state_e;

  // Major opcode nibble, instruction[15:12]
  localparam logic [3:0] OP_SYS     = 4'h0;
  localparam logic [3:0] OP_JP      = 4'h1;
  localparam logic [3:0] OP_CALL    = 4'h2;
  localparam logic [3:0] OP_SE_IMM  = 4'h3;
  localparam logic [3:0] OP_SNE_IMM = 4'h4;
  localparam logic [3:0] OP_SE_REG  = 4'h5;
  localparam logic [3:0] OP_LD_IMM  = 4'h6;
  localparam logic [3:0] OP_ADD_IMM = 4'h7;
  localparam logic [3:0] OP_ALU     = 4'h8;
  localparam logic [3:0] OP_SNE_REG = 4'h9;
  localparam logic [3:0] OP_LD_I    = 4'hA;
  localparam logic [3:0] OP_JP_V0   = 4'hB;
  localparam logic [3:0] OP_RND     = 4'hC;
  localparam logic [3:0] OP_DRW     = 4'hD;
  localparam logic [3:0] OP_SKP     = 4'hE;
  localparam logic [3:0] OP_MISC    = 4'hF;

  localparam logic [15:0] INSTR_CLS = 16'h00E0;
  localparam logic [15:0] INSTR_RET = 16'h00EE;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/fetch.sv
// CHIP-8 instruction fetch: reads two bytes per instruction over req/ack and
// hands the big-endian word to decode over valid/ready; execute may redirect.
module fetch #(
  parameter int                ADDR_W   = chip8_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = chip8_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [15:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] pc
);
  import chip8_pkg::*;

  fetch_state_e      state_q, state_d;
  fetch_state_e      resume_state;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_plus2;

  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign pc_plus2 = pc_q + ADDR_W'(2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      hi_q    <= 8'h00;
      instr_q <= 16'h0000;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hi_q    <= hi_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hi_d         = hi_q;
    instr_d      = instr_q;
    ipc_d        = ipc_q;
    valid_d      = valid_q;
    resume_state = fetch_en ? FS_REQ_HI : FS_IDLE;

    // A redirect discards any partial or held word, even one completing now
    if (redirect) begin
      pc_d    = redirect_addr;
      valid_d = 1'b0;
      state_d = resume_state;
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (fetch_en) state_d = FS_REQ_HI;
        end
        FS_REQ_HI: begin
          if (mem_ack) begin
            hi_d    = mem_data;
            state_d = FS_REQ_LO;
          end
        end
        FS_REQ_LO: begin
          if (mem_ack) begin
            instr_d = {hi_q, mem_data};
            ipc_d   = pc_q;
            pc_d    = pc_plus2;
            valid_d = 1'b1;
            state_d = FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (!valid_q || instr_ready) begin
            valid_d = 1'b0;
            state_d = resume_state;
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  assign mem_req     = (state_q == FS_REQ_HI) || (state_q == FS_REQ_LO);
  assign mem_addr    = (state_q == FS_REQ_HI) ? pc_q :
                       (state_q == FS_REQ_LO) ? pc_plus1 : '0;
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed cycle table, async reset sequence,
// then randomized traffic checked against a word-level program model.
module tb_fetch;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_en = 1'b0;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_data = 8'h00;
  logic          instr_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [15:0]   instruction;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic [AW-1:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:4095];

  always #5 clk = ~clk;

  fetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_addr(redirect_addr),
    .pc(pc)
  );

  typedef struct {
    logic        fen;
    logic        ack;
    logic [7:0]  data;
    logic        rdy;
    logic        rdr;
    logic [11:0] raddr;
    logic        e_req;
    logic [11:0] e_addr;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [11:0] e_ipc;
    logic [11:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fen, input logic ack, input logic [7:0] data,
                              input logic rdy, input logic rdr, input logic [11:0] raddr,
                              input logic e_req, input logic [11:0] e_addr, input logic e_valid,
                              input logic [15:0] e_instr, input logic [11:0] e_ipc,
                              input logic [11:0] e_pc);
    vec_t v;
    v.fen = fen; v.ack = ack; v.data = data; v.rdy = rdy; v.rdr = rdr; v.raddr = raddr;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_pc = e_pc;
    return v;
  endfunction

  initial begin
    logic [11:0] exp_pc;
    logic [11:0] nxt;
    logic        prev_stall, prev_hold;
    logic [11:0] prev_addr, prev_ipc;
    logic [15:0] prev_instr;
    int          accepted;

    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);

    //          fen ack data  rdy rdr raddr   req addr    vld instr     ipc     pc
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 12'h000, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h200));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 12'h000, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h200));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 12'h000, 1, 12'h200, 0, 16'h0000, 12'h000, 12'h200));
    vecs.push_back(mk(1, 1, 8'h12, 1, 0, 12'h000, 1, 12'h201, 0, 16'h0000, 12'h000, 12'h200));
    vecs.push_back(mk(1, 1, 8'h34, 1, 0, 12'h000, 0, 12'h000, 1, 16'h1234, 12'h200, 12'h202));
    vecs.push_back(mk(1, 1, 8'hFF, 1, 0, 12'h000, 1, 12'h202, 0, 16'h0000, 12'h000, 12'h202));
    vecs.push_back(mk(1, 1, 8'h56, 1, 0, 12'h000, 1, 12'h203, 0, 16'h0000, 12'h000, 12'h202));
    vecs.push_back(mk(1, 1, 8'h78, 0, 0, 12'h000, 0, 12'h000, 1, 16'h5678, 12'h202, 12'h204));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 1, 8'h99, 0, 0, 12'h000, 0, 12'h000, 1, 16'h5678, 12'h202, 12'h204));
    vecs.push_back(mk(1, 1, 8'h99, 1, 0, 12'h000, 1, 12'h204, 0, 16'h0000, 12'h000, 12'h204));
    vecs.push_back(mk(1, 1, 8'hAA, 1, 0, 12'h000, 1, 12'h205, 0, 16'h0000, 12'h000, 12'h204));
    vecs.push_back(mk(1, 1, 8'hBB, 1, 1, 12'h350, 1, 12'h350, 0, 16'h0000, 12'h000, 12'h350));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 0, 8'hEE, 1, 0, 12'h000, 1, 12'h350, 0, 16'h0000, 12'h000, 12'h350));
    vecs.push_back(mk(1, 1, 8'hC1, 1, 0, 12'h000, 1, 12'h351, 0, 16'h0000, 12'h000, 12'h350));
    vecs.push_back(mk(1, 1, 8'hD2, 1, 0, 12'h000, 0, 12'h000, 1, 16'hC1D2, 12'h350, 12'h352));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 12'h000, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h352));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 12'h000, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h352));
    vecs.push_back(mk(1, 0, 8'h00, 1, 1, 12'hFFF, 1, 12'hFFF, 0, 16'h0000, 12'h000, 12'hFFF));
    vecs.push_back(mk(1, 1, 8'hA2, 1, 0, 12'h000, 1, 12'h000, 0, 16'h0000, 12'h000, 12'hFFF));
    vecs.push_back(mk(1, 1, 8'h2A, 0, 0, 12'h000, 0, 12'h000, 1, 16'hA22A, 12'hFFF, 12'h001));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 12'h000, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h001));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 12'h000, 1, 12'h001, 0, 16'h0000, 12'h000, 12'h001));
    vecs.push_back(mk(1, 1, 8'h11, 0, 0, 12'h000, 1, 12'h002, 0, 16'h0000, 12'h000, 12'h001));
    vecs.push_back(mk(1, 1, 8'h22, 0, 0, 12'h000, 0, 12'h000, 1, 16'h1122, 12'h001, 12'h003));
    vecs.push_back(mk(1, 0, 8'h00, 1, 1, 12'h400, 1, 12'h400, 0, 16'h0000, 12'h000, 12'h400));
    vecs.push_back(mk(1, 1, 8'h33, 0, 0, 12'h000, 1, 12'h401, 0, 16'h0000, 12'h000, 12'h400));
    vecs.push_back(mk(1, 1, 8'h44, 0, 0, 12'h000, 0, 12'h000, 1, 16'h3344, 12'h400, 12'h402));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 12'h500, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h500));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 12'h600, 0, 12'h000, 0, 16'h0000, 12'h000, 12'h600));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 12'h700, 1, 12'h700, 0, 16'h0000, 12'h000, 12'h700));

    // Reset values while rst is held low
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", -1, 16'(mem_req), 16'h0);
    chk("rst_mem_addr", -1, 16'(mem_addr), 16'h0);
    chk("rst_valid", -1, 16'(instr_valid), 16'h0);
    chk("rst_instruction", -1, instruction, 16'h0);
    chk("rst_instr_pc", -1, 16'(instr_pc), 16'h0);
    chk("rst_pc", -1, 16'(pc), 16'h200);
    rst = 1'b1;

    foreach (vecs[i]) begin
      fetch_en = vecs[i].fen; mem_ack = vecs[i].ack; mem_data = vecs[i].data;
      instr_ready = vecs[i].rdy; redirect = vecs[i].rdr; redirect_addr = vecs[i].raddr;
      @(posedge clk);
      #1;
      chk("mem_req", i, 16'(mem_req), 16'(vecs[i].e_req));
      if (vecs[i].e_req) chk("mem_addr", i, 16'(mem_addr), 16'(vecs[i].e_addr));
      chk("instr_valid", i, 16'(instr_valid), 16'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk("instruction", i, instruction, vecs[i].e_instr);
        chk("instr_pc", i, 16'(instr_pc), 16'(vecs[i].e_ipc));
      end
      chk("pc", i, 16'(pc), 16'(vecs[i].e_pc));
      $display("vec %0d: req=%0b addr=%03h valid=%0b instr=%04h ipc=%03h pc=%03h",
               i, mem_req, mem_addr, instr_valid, instruction, instr_pc, pc);
    end

    // Asynchronous reset while the low-byte request is stalled
    redirect = 1'b0; instr_ready = 1'b0; fetch_en = 1'b1;
    mem_ack = 1'b1; mem_data = 8'h55;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_req", 100, 16'(mem_req), 16'h1);
    chk("stall_addr", 100, 16'(mem_addr), 16'h701);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_req", 101, 16'(mem_req), 16'h0);
    chk("arst_valid", 101, 16'(instr_valid), 16'h0);
    chk("arst_pc", 101, 16'(pc), 16'h200);
    chk("arst_instruction", 101, instruction, 16'h0);
    chk("arst_instr_pc", 101, 16'(instr_pc), 16'h0);
    $display("async reset: req=%0b valid=%0b pc=%03h", mem_req, instr_valid, pc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_req", 102, 16'(mem_req), 16'h1);
    chk("post_rst_addr", 102, 16'(mem_addr), 16'h200);

    // Randomized traffic: accepted words must follow the program-order model
    exp_pc = 12'h200;
    accepted = 0;
    prev_stall = 1'b0; prev_hold = 1'b0;
    prev_addr = '0; prev_ipc = '0; prev_instr = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (prev_stall) begin
        chk("rnd_req_held", cyc, 16'(mem_req), 16'h1);
        chk("rnd_addr_held", cyc, 16'(mem_addr), 16'(prev_addr));
      end
      if (prev_hold) begin
        chk("rnd_valid_held", cyc, 16'(instr_valid), 16'h1);
        chk("rnd_instr_held", cyc, instruction, prev_instr);
        chk("rnd_ipc_held", cyc, 16'(instr_pc), 16'(prev_ipc));
        chk("rnd_hold_noreq", cyc, 16'(mem_req), 16'h0);
      end

      fetch_en      = ($urandom_range(0, 9) != 0);
      instr_ready   = ($urandom_range(0, 9) < 7);
      redirect      = ($urandom_range(0, 39) == 0);
      redirect_addr = 12'($urandom);
      mem_ack       = mem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      mem_data      = (mem_req && mem_ack) ? mem[mem_addr] : 8'($urandom);

      if (instr_valid && instr_ready) begin
        nxt = exp_pc + 12'd1;
        chk("rnd_instr_pc", cyc, 16'(instr_pc), 16'(exp_pc));
        chk("rnd_instruction", cyc, instruction, {mem[exp_pc], mem[nxt]});
        $display("accept %0d: pc=%03h instr=%04h", accepted, instr_pc, instruction);
        accepted++;
        exp_pc = exp_pc + 12'd2;
      end
      if (redirect) exp_pc = redirect_addr;

      prev_stall = mem_req && !mem_ack && !redirect;
      prev_addr  = mem_addr;
      prev_hold  = instr_valid && !instr_ready && !redirect;
      prev_instr = instruction;
      prev_ipc   = instr_pc;
      @(posedge clk);
      #1;
    end

    n_checks++;
    if (accepted < 100) begin
      n_fail++;
      $display("FAIL rnd_liveness: got %0d accepted words, expected at least 100", accepted);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
